toy_mem_responder: RTL and testbench

- Main-memory responder for the TOY core: 256 x 16-bit word store, slave end of the core's instruction-fetch read ports and its load/store read-write port.
- Storage is split into 2^BANK_BITS address-interleaved banks. Each bank services one access per cycle.
- Bank conflicts are resolved by stalling the losers with rdy low.
- Read data is returned in the same cycle as rdy, so the core latches rdata on val && rdy.

---
 rtl/toy_mem_if.sv | 32 +++
 rtl/toy_mem_responder.sv | 101 ++++++++++
 tb/tb_toy_mem_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/toy_mem_if.sv
// Bus bundle between the TOY core and its main-memory responder:
// RPORTS fetch read ports plus one load/store read-write port.
interface toy_mem_if #(
  parameter int RPORTS = 2
);
  logic [RPORTS-1:0]    r_val_i;
  logic [8*RPORTS-1:0]  r_addr_i;
  logic [RPORTS-1:0]    r_rdy_o;
  logic [16*RPORTS-1:0] r_rdata_o;
  logic                 rw_val_i;
  logic                 rw_wen_i;
  logic [7:0]           rw_addr_i;
  logic [15:0]          rw_wdata_i;
  logic                 rw_rdy_o;
  logic [15:0]          rw_rdata_o;

  modport master (
    output r_val_i, r_addr_i,
    input  r_rdy_o, r_rdata_o,
    output rw_val_i, rw_wen_i,
    output rw_addr_i, rw_wdata_i,
    input  rw_rdy_o, rw_rdata_o
  );

  modport slave (
    input  r_val_i, r_addr_i,
    output r_rdy_o, r_rdata_o,
    input  rw_val_i, rw_wen_i,
    input  rw_addr_i, rw_wdata_i,
    output rw_rdy_o, rw_rdata_o
  );
endinterface

// File: rtl/toy_mem_responder.sv
// 256x16 banked memory responder: RPORTS read ports + 1 rw port.
// Ports: clk_i, arst_ni, bus (toy_mem_if.slave), conflict_cnt_o.
module toy_mem_responder #(
  parameter int RPORTS    = 2,
  parameter int BANK_BITS = 1
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  toy_mem_if.slave    bus,
  output logic [15:0] conflict_cnt_o
);

  localparam int NB = 1 << BANK_BITS;
  localparam int PW = (RPORTS > 1) ? $clog2(RPORTS) : 1;

  logic [15:0]       mem    [256];
  logic [PW-1:0]     rr     [NB];
  logic [PW-1:0]     rr_nxt [NB];
  logic [7:0]        raddr  [RPORTS];
  logic [RPORTS-1:0] rdy;
  logic              stall;

  function automatic int bank_of(logic [7:0] a);
    return int'(a) % NB;
  endfunction

  for (genvar p = 0; p < RPORTS; p++) begin : g_port
    assign raddr[p] = bus.r_addr_i[8*p +: 8];
    assign bus.r_rdata_o[16*p +: 16] = mem[raddr[p]];
  end

  assign bus.rw_rdata_o = mem[bus.rw_addr_i];
  assign bus.rw_rdy_o   = arst_ni;
  assign bus.r_rdy_o    = rdy;

  // Arbitration looks only at addresses, never at r_val_i,
  // so rdy carries no combinational path from val.
  always_comb begin
    logic own;
    logic any;
    int   win;
    int   idx;
    own = 1'b0;
    any = 1'b0;
    win = 0;
    idx = 0;
    rdy = '0;
    for (int b = 0; b < NB; b++) begin
      rr_nxt[b] = rr[b];
      own = bus.rw_val_i &&
            (bank_of(bus.rw_addr_i) == b);
      any = 1'b0;
      win = 0;
      for (int k = 0; k < RPORTS; k++) begin
        idx = (int'(rr[b]) + k) % RPORTS;
        if (!any && bank_of(raddr[idx]) == b) begin
          any = 1'b1;
          win = idx;
        end
      end
      if (any && !own) begin
        rr_nxt[b] = PW'((win + 1) % RPORTS);
        // same-word requesters share the winner's access
        for (int p = 0; p < RPORTS; p++) begin
          if (bank_of(raddr[p]) == b &&
              raddr[p] == raddr[win])
            rdy[p] = 1'b1;
        end
      end
    end
  end

  assign stall = |(bus.r_val_i & ~rdy);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= '0;
    end else if (bus.rw_val_i && bus.rw_wen_i) begin
      mem[bus.rw_addr_i] <= bus.rw_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int b = 0; b < NB; b++)
        rr[b] <= '0;
    end else begin
      for (int b = 0; b < NB; b++)
        rr[b] <= rr_nxt[b];
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni)
      conflict_cnt_o <= '0;
    else if (stall && conflict_cnt_o != 16'hFFFF)
      conflict_cnt_o <= conflict_cnt_o + 16'd1;
  end

endmodule

// File: tb/tb_toy_mem_responder.sv
// Bench for toy_mem_responder: directed steps then random traffic,
// all checked against a word-array / round-robin reference model.
module tb_toy_mem_responder;

  localparam int RP = 2;
  localparam int NB = 2;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [15:0] cnt;

  toy_mem_if #(.RPORTS(RP)) bus ();

  toy_mem_responder #(
    .RPORTS   (RP),
    .BANK_BITS(1)
  ) dut (
    .clk_i         (clk),
    .arst_ni       (arst_n),
    .bus           (bus),
    .conflict_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  int          mm   [256];
  int          mrr  [NB];
  int          mcnt;
  int          ewin [NB];
  bit          egnt [NB];
  logic [1:0]  erdy;
  int          total;
  int          passed;

  function automatic int ra(int p);
    return int'(bus.r_addr_i[8*p +: 8]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mm[i] = 0;
    for (int b = 0; b < NB; b++) mrr[b] = 0;
    mcnt = 0;
  endtask

  // who may read this cycle, from the bank-ownership rules
  task automatic model_arb();
    int p;
    for (int b = 0; b < NB; b++) begin
      egnt[b] = 0;
      ewin[b] = 0;
      if (!(bus.rw_val_i && int'(bus.rw_addr_i) % NB == b)) begin
        for (int k = 0; k < RP; k++) begin
          p = (mrr[b] + k) % RP;
          if (!egnt[b] && ra(p) % NB == b) begin
            egnt[b] = 1;
            ewin[b] = p;
          end
        end
      end
    end
    for (int q = 0; q < RP; q++) begin
      erdy[q] = egnt[ra(q) % NB] &&
                ra(q) == ra(ewin[ra(q) % NB]);
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total += 1;
    assert (obs === exp) passed += 1;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic drv_r(logic v0, logic [7:0] a0,
                       logic v1, logic [7:0] a1);
    bus.r_val_i  = {v1, v0};
    bus.r_addr_i = {a1, a0};
  endtask

  task automatic drv_rw(logic v, logic w, logic [7:0] a,
                        logic [15:0] d);
    bus.rw_val_i   = v;
    bus.rw_wen_i   = w;
    bus.rw_addr_i  = a;
    bus.rw_wdata_i = d;
  endtask

  task automatic settle();
    #1;
    model_arb();
    for (int p = 0; p < RP; p++) begin
      chk($sformatf("rdy%0d", p), 32'(bus.r_rdy_o[p]),
          32'(erdy[p]));
      chk($sformatf("rdata%0d", p),
          32'(bus.r_rdata_o[16*p +: 16]), 32'(mm[ra(p)]));
    end
    chk("rw_rdy", 32'(bus.rw_rdy_o), 32'd1);
    chk("rw_rdata", 32'(bus.rw_rdata_o),
        32'(mm[int'(bus.rw_addr_i)]));
    chk("cnt", 32'(cnt), 32'(mcnt));
  endtask

  task automatic tick();
    @(posedge clk);
    if (bus.rw_val_i && bus.rw_wen_i)
      mm[int'(bus.rw_addr_i)] = int'(bus.rw_wdata_i);
    for (int b = 0; b < NB; b++)
      if (egnt[b]) mrr[b] = (ewin[b] + 1) % RP;
    if (|(bus.r_val_i & ~erdy) && mcnt < 65535)
      mcnt += 1;
    #1;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #2;
    arst_n = 1'b1;
    model_reset();
  endtask

  logic [1:0] alt_exp [4];

  initial begin
    total  = 0;
    passed = 0;
    alt_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    model_reset();
    drv_r(1'b0, 8'h00, 1'b0, 8'h01);
    drv_rw(1'b0, 1'b0, 8'h00, 16'h0);
    #3 arst_n = 1'b1;

    settle();
    chk("reset_cnt", 32'(cnt), 32'd0);
    tick();

    // two banks, two ports: no conflict
    drv_r(1'b1, 8'h10, 1'b1, 8'h11);
    settle();
    chk("t1_rdy", 32'(bus.r_rdy_o), 32'h3);
    chk("t1_rd0", 32'(bus.r_rdata_o[15:0]), 32'h0);
    tick();

    // write in bank 0, read in bank 1
    drv_rw(1'b1, 1'b1, 8'h20, 16'h1234);
    drv_r(1'b1, 8'h21, 1'b0, 8'h20);
    settle();
    chk("t2_rdy0", 32'(bus.r_rdy_o[0]), 32'd1);
    tick();
    drv_rw(1'b0, 1'b0, 8'h00, 16'h0);
    drv_r(1'b1, 8'h20, 1'b0, 8'h21);
    settle();
    chk("t2_rd0", 32'(bus.r_rdata_o[15:0]), 32'h1234);
    tick();

    // rw owns the bank, read stalls
    drv_rw(1'b1, 1'b1, 8'h10, 16'hBEEF);
    drv_r(1'b1, 8'h10, 1'b0, 8'h21);
    settle();
    chk("t3_rdy0", 32'(bus.r_rdy_o[0]), 32'd0);
    chk("t3_old", 32'(bus.r_rdata_o[15:0]), 32'h0);
    tick();
    chk("t3_cnt", 32'(cnt), 32'd1);
    drv_rw(1'b0, 1'b0, 8'h00, 16'h0);
    settle();
    chk("t3b_rdy0", 32'(bus.r_rdy_o[0]), 32'd1);
    chk("t3b_rd0", 32'(bus.r_rdata_o[15:0]), 32'hBEEF);
    tick();

    // broadcast on the same word
    drv_r(1'b1, 8'h30, 1'b1, 8'h30);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bc_rdy", 32'(bus.r_rdy_o), 32'h3);
      tick();
    end
    chk("bc_cnt", 32'(cnt), 32'd1);

    // mid-operation reset between edges
    drv_rw(1'b1, 1'b1, 8'h40, 16'h5555);
    drv_r(1'b0, 8'h41, 1'b0, 8'h41);
    settle();
    tick();
    drv_rw(1'b0, 1'b0, 8'h40, 16'h0);
    drv_r(1'b1, 8'h40, 1'b0, 8'h41);
    settle();
    chk("pre_rst", 32'(bus.r_rdata_o[15:0]), 32'h5555);
    do_reset();
    settle();
    chk("rst_rd", 32'(bus.r_rdata_o[15:0]), 32'h0);
    chk("rst_rw", 32'(bus.rw_rdata_o), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'd0);

    // rdy must not follow val
    drv_r(1'b0, 8'h10, 1'b0, 8'h12);
    settle();
    chk("nv_rdy00", 32'(bus.r_rdy_o), 32'h1);
    drv_r(1'b0, 8'h10, 1'b1, 8'h12);
    settle();
    chk("nv_rdy10", 32'(bus.r_rdy_o), 32'h1);
    drv_r(1'b1, 8'h10, 1'b1, 8'h12);
    settle();
    chk("nv_rdy11", 32'(bus.r_rdy_o), 32'h1);

    // same-bank contention alternates
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("alt%0d", i), 32'(bus.r_rdy_o),
          32'(alt_exp[i]));
      tick();
    end
    chk("alt_cnt", 32'(cnt), 32'd4);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a0, a1, wa;
      a0 = ($urandom_range(0, 3) == 0) ? 8'($urandom)
         : 8'(8'h10 + $urandom_range(0, 3));
      a1 = ($urandom_range(0, 3) == 0) ? 8'($urandom)
         : 8'(8'h10 + $urandom_range(0, 3));
      wa = 8'(8'h10 + $urandom_range(0, 7));
      drv_r(1'($urandom), a0, 1'($urandom), a1);
      drv_rw(($urandom_range(0, 9) < 3), 1'($urandom),
             wa, 16'($urandom));
      settle();
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
